// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port shared by the ALU and load paths.
// Load has fixed priority; a starvation counter forces an ALU grant after STARVE_LIMIT refusals.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] q_addr1,
  input  logic [ADDR_WIDTH-1:0] q_addr2,
  output logic                  q_hit1,
  output logic                  q_hit2,
  output logic [DATA_WIDTH-1:0] q_data1,
  output logic [DATA_WIDTH-1:0] q_data2
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_LD,
    GRANT_ALU
  } grant_t;

  grant_t                grant;
  logic [CNT_W-1:0]      starve_cnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    grant = GRANT_NONE;
    if (!rst) begin
      if (alu_valid && (starve_cnt == STARVE_MAX)) begin
        grant = GRANT_ALU;
      end else if (ld_valid) begin
        grant = GRANT_LD;
      end else if (alu_valid) begin
        grant = GRANT_ALU;
      end
    end
  end

  assign alu_ready = (grant == GRANT_ALU);
  assign ld_ready  = (grant == GRANT_LD);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (grant)
      GRANT_ALU: begin
        sel_addr = alu_addr;
        sel_data = alu_data;
      end
      GRANT_LD: begin
        sel_addr = ld_addr;
        sel_data = ld_data;
      end
      default: begin
        sel_addr = '0;
        sel_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // x0 writes are accepted and staged, but never enable the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant != GRANT_NONE) begin
      rf_we    <= (sel_addr != '0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always_comb begin
    q_hit1  = rf_we && (rf_waddr == q_addr1) && (q_addr1 != '0);
    q_hit2  = rf_we && (rf_waddr == q_addr2) && (q_addr2 != '0);
    q_data1 = q_hit1 ? rf_wdata : '0;
    q_data2 = q_hit2 ? rf_wdata : '0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ld_valid, alu_ready, ld_ready;
  logic [AW-1:0] alu_addr, ld_addr, rf_waddr, q_addr1, q_addr2;
  logic [DW-1:0] alu_data, ld_data, rf_wdata, q_data1, q_data2;
  logic          rf_we, q_hit1, q_hit2;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2)
  );

  typedef struct {
    logic          ar, lr;
    logic          chk_we, chk_ad;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          h1, h2;
    logic [DW-1:0] d1, d2;
  } cyc_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  cyc_t cq[$];
  wr_t  wq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: consumes one expected-cycle record per cycle and one write per rf_we pulse.
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      cyc_t e;
      e = cq.pop_front();
      chk("alu_ready", 64'(alu_ready), 64'(e.ar));
      chk("ld_ready", 64'(ld_ready), 64'(e.lr));
      if (e.chk_we) begin
        chk("rf_we", 64'(rf_we), 64'(e.we));
        chk("q_hit1", 64'(q_hit1), 64'(e.h1));
        chk("q_hit2", 64'(q_hit2), 64'(e.h2));
        chk("q_data1", 64'(q_data1), 64'(e.d1));
        chk("q_data2", 64'(q_data2), 64'(e.d2));
        if (rf_we === 1'b1) begin
          if (wq.size() == 0) begin
            chk("unexpected_write", 64'(1), 64'(0));
          end else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", 64'(rf_waddr), 64'(w.a));
            chk("wr_data", 64'(rf_wdata), 64'(w.d));
          end
        end
      end
      if (e.chk_ad) begin
        chk("rf_waddr", 64'(rf_waddr), 64'(e.wa));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.wd));
      end
    end
  end

  // Requester state (held until accepted) and reference model state.
  logic          a_v = 1'b0, l_v = 1'b0;
  logic [AW-1:0] a_a = '0, l_a = '0;
  logic [DW-1:0] a_d = '0, l_d = '0;
  int            alu_wait = 0;
  logic          m_known = 1'b0, m_chk = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;

  task automatic run_cycle(input logic r, input logic [AW-1:0] q1, input logic [AW-1:0] q2);
    logic ga, gl;
    logic [AW-1:0] ad;
    logic [DW-1:0] da;
    cyc_t e;
    rst = r;
    alu_valid = a_v; alu_addr = a_a; alu_data = a_d;
    ld_valid = l_v;  ld_addr = l_a;  ld_data = l_d;
    q_addr1 = q1; q_addr2 = q2;
    ga = 1'b0; gl = 1'b0;
    if (!r) begin
      if (a_v && alu_wait >= LIMIT) ga = 1'b1;
      else if (l_v) gl = 1'b1;
      else if (a_v) ga = 1'b1;
    end
    e.ar = ga; e.lr = gl;
    e.chk_we = m_known; e.chk_ad = m_chk;
    e.we = m_we; e.wa = m_wa; e.wd = m_wd;
    e.h1 = m_we && (m_wa == q1) && (q1 != 0);
    e.h2 = m_we && (m_wa == q2) && (q2 != 0);
    e.d1 = e.h1 ? m_wd : '0;
    e.d2 = e.h2 ? m_wd : '0;
    cq.push_back(e);
    @(posedge clk); #1;
    if (r) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_known = 1'b1; m_chk = 1'b1;
    end else if (ga || gl) begin
      ad = ga ? a_a : l_a;
      da = ga ? a_d : l_d;
      m_we = (ad != 0);
      m_wa = ad; m_wd = da;
      m_chk = (ad != 0);
      if (ad != 0) wq.push_back('{a: ad, d: da});
    end else begin
      m_we = 1'b0;
    end
    if (r || !a_v || ga) alu_wait = 0;
    else if (alu_wait < LIMIT) alu_wait++;
    if (ga) a_v = 1'b0;
    if (gl) l_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid = 1'b0;  ld_addr = '0;  ld_data = '0;
    q_addr1 = '0; q_addr2 = '0;
    @(posedge clk); #1;
    run_cycle(1'b1, 0, 0);
    run_cycle(1'b1, 0, 0);

    a_v = 1; a_a = 5; a_d = 32'hDEADBEEF;
    run_cycle(0, 5, 0); run_cycle(0, 5, 0); run_cycle(0, 5, 0);

    a_v = 1; a_a = 3; a_d = 32'h11;
    l_v = 1; l_a = 4; l_d = 32'h22;
    run_cycle(0, 3, 4); run_cycle(0, 3, 4); run_cycle(0, 3, 4); run_cycle(0, 0, 0);

    a_v = 1; a_a = 9; a_d = 32'hA0;
    for (int i = 0; i < 8; i++) begin
      if (!l_v) begin l_v = 1; l_a = 5'(10 + i); l_d = 32'hB00 + 32'(i); end
      run_cycle(0, 9, 5'(10 + i));
    end
    l_v = 0;
    run_cycle(0, 0, 0); run_cycle(0, 0, 0);

    l_v = 1; l_a = 0; l_d = 32'hFFFFFFFF;
    run_cycle(0, 0, 0); run_cycle(0, 0, 0); run_cycle(0, 0, 0);

    a_v = 1; a_a = 7; a_d = 32'h1234;
    run_cycle(0, 7, 8); run_cycle(0, 7, 8); run_cycle(0, 7, 8);

    a_v = 1; a_a = 6; a_d = 32'h55;
    run_cycle(0, 6, 0); run_cycle(1, 6, 0); run_cycle(0, 6, 0); run_cycle(0, 6, 0);

    for (int i = 0; i < 500; i++) begin
      logic [AW-1:0] q1, q2;
      if (!a_v && ($urandom % 3 != 0)) begin
        a_v = 1; a_a = 5'($urandom % 32); a_d = $urandom;
      end
      if (!l_v && ($urandom % 4 != 0)) begin
        l_v = 1; l_a = 5'($urandom % 32); l_d = $urandom;
      end
      if ($urandom % 16 == 0) a_a = '0;
      q1 = ($urandom % 2 == 0) ? m_wa : 5'($urandom % 32);
      q2 = ($urandom % 3 == 0) ? m_wa : 5'($urandom % 32);
      run_cycle(($urandom % 80) == 0, q1, q2);
    end

    a_v = 0; l_v = 0;
    run_cycle(0, 0, 0); run_cycle(0, 0, 0); run_cycle(0, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("writes_drained", 64'(wq.size()), 64'(0));
    chk("cycles_drained", 64'(cq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
